greenhouse_ctrl: RTL
====================

# greenhouse_ctrl

Multi-zone greenhouse climate controller, the parametrised sequential successor to the single-zone combinational heat/cool indicator on the board top level. Each of `NZONES` zones reads a 2-bit temperature-sensor code, debounces it, and drives a heater or cooler through a per-zone state machine. The state machine enforces minimum-on time, dead-time between heating and cooling, and sensor-fault alarm handling. The block instantiates in `top` with sensors on `SWI` and outputs on `LED`/`SEG`.

## Interface
- `NZONES`, 4: number of independent zones (1..8).
- `DEBOUNCE`, 4: consecutive identical samples required before a sensor code is accepted (≥1).
- `MIN_ON`, 8: minimum cycles a zone stays in HEAT or COOL once entered (≥1).
- `clk_2`  input  1  system clock, all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `sens`  input  2*NZONES  zone z code at `sens[2z+1:2z]`: 00 cold, 01 normal, 11 hot, 10 invalid.
- `fault_ack`  input  1  single-cycle acknowledge, global to all zones.
- `heater`  output  NZONES  heater enable per zone.
- `cooler`  output  NZONES  cooler enable per zone.
- `alarm`  output  NZONES  sensor-fault indicator per zone.
- `busy_cnt`  output  $clog2(NZONES+1)  number of zones with heater or cooler on.

## Operation
- Per zone, `sens` is registered into a sample register `s_q` every cycle.
- Debouncer: the accepted code `db` takes a new value only after `s_q` holds that value for `DEBOUNCE` consecutive samples. Any change of `s_q` restarts the count.
- FSM states are IDLE, HEAT, COOL, FAULT. Outputs are Moore-decoded from state: HEAT → heater=1; COOL → cooler=1; FAULT → alarm=1; all other outputs 0.
- IDLE transitions:
  - `db`=00 → HEAT.
  - `db`=11 → COOL.
  - `db`=10 → FAULT.
  - `db`=01 → stay in IDLE.
- HEAT/COOL transitions:
  - A `min_cnt` is loaded on entry.
  - Before `MIN_ON` cycles have elapsed, only `db`=10 can cause an exit, and it goes to FAULT.
  - After `MIN_ON` cycles have elapsed, any `db` other than the current demand (00 for HEAT, 11 for COOL) → IDLE.
  - There is never a direct HEAT↔COOL transition. The zone spends at least one cycle in IDLE between them (dead-time).
- FAULT: `db`=10 from any state → FAULT on the next edge. This overrides min-on.
- FAULT exit: see Configuration.
- `busy_cnt` is the combinational popcount of `heater | cooler`.
- Zones are fully independent. `fault_ack` is applied to every zone in FAULT simultaneously.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - State is IDLE.
  - `s_q` and `db` are 01.
  - All counters are 0.
  - `heater`, `cooler` and `alarm` are all 0; `busy_cnt` is 0.
- Latency: a code applied before edge k and held is captured in `s_q` at edge k. `db` updates at edge k+DEBOUNCE-1. State and outputs change at edge k+DEBOUNCE.
- Glitch rejection: a code held for fewer than `DEBOUNCE` samples produces no state change.
- Min-on: if HEAT/COOL is entered at edge e, the earliest exit to IDLE is edge e+MIN_ON. The earliest subsequent entry into the opposite mode is edge e+MIN_ON+1.
- Simultaneous events: if `fault_ack` arrives in the same cycle as `db` becoming 10, FAULT holds (fault wins).
- Reset mid-operation forces the reset values immediately, regardless of state or counters.
- Counters saturate and do not wrap.

## Configuration
- Macro: `GREENHOUSE_FAULT_LATCH_EN`.
- Defined: FAULT is latched. A zone leaves FAULT (→ IDLE) only on an edge where `fault_ack`=1 and that zone's `db`=01. Otherwise the zone stays in FAULT with `alarm`=1.
- Undefined: FAULT auto-clears. A zone returns to IDLE on the first edge where `db`≠10. `fault_ack` is ignored.

## Test plan
- Reset and normal hold: hold `reset_n`=0 for 3 cycles with `sens`=all 01, then release. Required: all outputs 0 and `busy_cnt`=0 for 20 cycles.
- Debounce and latency (defaults): zone 0 `sens`=00 applied before edge 1 and held. Required: heater[0]=1 after edge 5 and not before. Separately, a 3-cycle 00 pulse must leave heater[0]=0.
- Min-on and dead-time: zone 1 `sens`=11 until COOL is entered at edge e, then `sens`=00 immediately. Required: cooler[1]=1 through edge e+7, IDLE at e+8, heater[1]=1 at e+9; cooler and heater are never both 1.
- Fault override: zone 2 in HEAT, then `sens`=10 held for 4 samples. Required: heater[2]=0 and alarm[2]=1 on the next edge after `db` update, even inside the min-on window.
- Fault clear, with the macro defined:
  - Zone 2 `sens` back to 01 and debounced; `fault_ack` pulse in the same cycle as a fresh `db`=10 on zone 3. Required: alarm[2] clears, alarm[3] sets.
  - Without the macro: alarm[2] clears when `db` leaves 10, with no ack.
- Multi-zone count and async reset: zones 0–3 driven to 00, 11, 00, 01. Required: `busy_cnt`=3. Asserting `reset_n`=0 mid-MIN_ON clears all outputs within the same cycle.

Source files
------------

// File: rtl/greenhouse_ctrl.sv
// Multi-zone climate controller: per zone sample, debounce, then IDLE/HEAT/COOL/FAULT FSM.
// Outputs change DEBOUNCE edges after the sensor code is sampled; no backpressure; GREENHOUSE_FAULT_LATCH_EN latches FAULT until acked.
module greenhouse_ctrl #(
    parameter int NZONES   = 4,
    parameter int DEBOUNCE = 4,
    parameter int MIN_ON   = 8
) (
    input  logic                        clk_2,
    input  logic                        reset_n,
    input  logic [2*NZONES-1:0]         sens,
    input  logic                        fault_ack,
    output logic [NZONES-1:0]           heater,
    output logic [NZONES-1:0]           cooler,
    output logic [NZONES-1:0]           alarm,
    output logic [$clog2(NZONES+1)-1:0] busy_cnt
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int MW = $clog2(MIN_ON + 1);
    localparam int BW = $clog2(NZONES + 1);

    localparam logic [1:0] C_COLD = 2'b00;
    localparam logic [1:0] C_NORM = 2'b01;
    localparam logic [1:0] C_INV  = 2'b10;
    localparam logic [1:0] C_HOT  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_HEAT, ST_COOL, ST_FAULT} state_t;

`ifndef GREENHOUSE_FAULT_LATCH_EN
    logic ack_unused;
    assign ack_unused = fault_ack;
`endif

    for (genvar z = 0; z < NZONES; z++) begin : g_zone
        logic [1:0]    sens_z;
        logic [1:0]    s_q, s_d, db_q, db_d;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [MW-1:0] min_q, min_d;
        state_t        state_q, state_d;
        logic          heat_q, heat_d, cool_q, cool_d, alarm_q, alarm_d;

        assign sens_z = sens[2*z +: 2];

        always_comb begin
            s_d   = sens_z;
            db_d  = db_q;
            // cnt counts repeat samples beyond the first; the code is accepted once it reaches DEBOUNCE-1
            if (sens_z == s_q) begin
                cnt_d = (cnt_q == DW'(DEBOUNCE - 1)) ? cnt_q : cnt_q + DW'(1);
            end else begin
                cnt_d = '0;
            end
            if (cnt_d == DW'(DEBOUNCE - 1)) begin
                db_d = sens_z;
            end

            state_d = state_q;
            min_d   = (min_q != '0) ? min_q - MW'(1) : min_q;
            case (state_q)
                ST_IDLE: begin
                    if (db_q == C_COLD) begin
                        state_d = ST_HEAT;
                        min_d   = MW'(MIN_ON - 1);
                    end else if (db_q == C_HOT) begin
                        state_d = ST_COOL;
                        min_d   = MW'(MIN_ON - 1);
                    end
                end
                ST_HEAT: if (min_q == '0 && db_q != C_COLD) state_d = ST_IDLE;
                ST_COOL: if (min_q == '0 && db_q != C_HOT)  state_d = ST_IDLE;
                ST_FAULT: begin
`ifdef GREENHOUSE_FAULT_LATCH_EN
                    if (fault_ack && db_q == C_NORM) state_d = ST_IDLE;
`else
                    if (db_q != C_INV) state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
            // An invalid code overrides min-on and any simultaneous acknowledge
            if (db_q == C_INV) begin
                state_d = ST_FAULT;
            end

            heat_d  = (state_d == ST_HEAT);
            cool_d  = (state_d == ST_COOL);
            alarm_d = (state_d == ST_FAULT);
        end

        always_ff @(posedge clk_2 or negedge reset_n) begin
            if (!reset_n) begin
                s_q     <= C_NORM;
                db_q    <= C_NORM;
                cnt_q   <= '0;
                min_q   <= '0;
                state_q <= ST_IDLE;
                heat_q  <= 1'b0;
                cool_q  <= 1'b0;
                alarm_q <= 1'b0;
            end else begin
                s_q     <= s_d;
                db_q    <= db_d;
                cnt_q   <= cnt_d;
                min_q   <= min_d;
                state_q <= state_d;
                heat_q  <= heat_d;
                cool_q  <= cool_d;
                alarm_q <= alarm_d;
            end
        end

        assign heater[z] = heat_q;
        assign cooler[z] = cool_q;
        assign alarm[z]  = alarm_q;
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NZONES; i++) begin
            busy_cnt = busy_cnt + BW'(heater[i] | cooler[i]);
        end
    end

endmodule
